irq_queue_ctrl: RTL and testbench
=================================

# irq_queue_ctrl

Parametrised interrupt front-end placed between the peripheral interrupt lines and the core's interrupt entry logic. Detects rising edges on N_SRC request lines, holds one pending bit per source, arbitrates one source per cycle into a DEPTH-entry FIFO of source IDs, and presents the oldest ID to the core under a valid/ack handshake. It generalises the fixed 7-line collector and 16-entry queue to arbitrary width and depth, and adds masking, a drop flag, an occupancy count and a selectable arbitration policy.

## Interface
- N_SRC, 7, number of interrupt sources (1..31)
- DEPTH, 16, FIFO entries (power of two, >= 2)
- ID_W (localparam), $clog2(N_SRC+1), ID width; CW (localparam), $clog2(DEPTH+1), count width
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- irq_in  in  N_SRC  request lines, bit i = source i+1
- mask  in  N_SRC  1 = source enabled
- ack  in  1  core consumes head entry (eirq equivalent)
- clr_drop  in  1  clears drop flag
- irq_valid  out  1  FIFO non-empty, irq_id meaningful
- irq_id  out  ID_W  head ID, 1..N_SRC; 0 when empty
- count  out  CW  FIFO occupancy
- full  out  1  count == DEPTH
- drop  out  1  sticky: an edge was lost

## Operation
- Edge detect: prev register per line; edge[i] = irq_in[i] & ~prev[i]. prev resets to 0, so a line already high at reset release counts as an edge.
- Pending: pend[i] set on edge[i] & mask[i]; cleared when source i is granted. Edge on an enabled source already pending (and not granted that cycle) is lost: drop <= 1. Masked edges are ignored silently, no drop. Mask gates latching only; an existing pending bit is still arbitrated after masking.
- Grant: at most one per cycle, only if pend != 0 and push is allowed. Push allowed when count < DEPTH, or count == DEPTH and a pop occurs the same cycle.
- Arbitration (default, round-robin): search starts at index rr_ptr, wraps modulo N_SRC; first pending index wins; rr_ptr <= winner+1 (wrap to 0 at N_SRC). rr_ptr resets to 0.
- FIFO: entry = winner+1. Pop when ack & irq_valid; ack while empty is ignored. Push and pop same cycle: count unchanged, order preserved.
- FIFO full: pending bits held, nothing lost; drop only from re-edge on a pending source.
- drop: set has priority over clr_drop in the same cycle.

## Timing
- Reset: irq_valid 0, irq_id 0, count 0, full 0, drop 0; pend, prev, rr_ptr, FIFO pointers 0.
- Edge sampled at cycle t -> pend visible t+1 -> granted/pushed end of t+1 -> irq_valid=1 with ID at t+2 (empty FIFO, no competing sources).
- Pop: ack high at cycle t with irq_valid -> next entry (or empty) visible at t+1.
- Outputs registered or decoded from registered state only; no combinational path from irq_in or ack to any output.
- rst mid-operation: all queued and pending interrupts discarded in one cycle.

## Configuration
- IRQ_FIXED_PRIO_EN defined: fixed priority, highest index (largest ID) always wins; rr_ptr not implemented.
- Undefined: round-robin as above.

## Structure
- Package irq_pkg: ID_NONE = 0 constant, id_width function ($clog2(n+1)), grant-select function used by both policies.
- Sub-module irq_fifo (DEPTH, ID_W): storage, wrap-around rd/wr pointers, count, full; push/pop/simultaneous rules above.
- Edge detect, pending, arbiter and drop logic stay in irq_queue_ctrl.

## Test plan (N_SRC=7, DEPTH=4)
- Reset release with irq_in=7'b0000100, mask all 1 -> irq_valid=1, irq_id=3 two cycles after release; ack -> irq_valid=0 next cycle.
- Edges on sources 2,5,7 same cycle, round-robin -> IDs 2,5,7 in order; with IRQ_FIXED_PRIO_EN -> 7,5,2.
- Six single-source edges, no ack -> count=4, full=1, two still pending; ack once -> next pending pushed, count stays 4, no drop.
- Source 4 pulsed twice while FIFO full and pend[4]=1 -> drop=1; clr_drop -> drop=0; only one ID 4 queued.
- mask[1]=0, pulse source 1 -> no pend, no drop, irq_valid stays 0.
- FIFO holding 3 entries, assert rst one cycle -> count=0, irq_valid=0, irq_id=0 next cycle.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants, types and the grant-select function for the interrupt queue.
// The selection policy (round-robin or fixed priority) is chosen by the caller.
package irq_pkg;

    localparam int ID_NONE = 0;
    localparam int MAX_SRC = 32;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } grant_t;

    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

    // Walks n candidates, either upward from start with wrap-around or downward from n-1.
    function automatic grant_t grant_select(input logic [MAX_SRC-1:0] pend, input int n,
                                            input int start, input logic high_first);
        grant_t g;
        int     idx;
        g = '0;
        for (int k = 0; k < MAX_SRC; k++) begin
            if (k < n && !g.found) begin
                idx = high_first ? (n - 1 - k) : (start + k);
                if (idx >= n) idx = idx - n;
                if (pend[idx[4:0]]) begin
                    g.found = 1'b1;
                    g.idx   = idx[4:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/irq_fifo.sv
// Queue of granted source IDs with wrap-around pointers and an occupancy count.
// A pop frees a slot for a push in the same cycle, so a full queue can still accept.
module irq_fifo
    import irq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int ID_W  = 3,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [ID_W-1:0] din,
    output logic [ID_W-1:0] dout,
    output logic            valid,
    output logic [CW-1:0]   count,
    output logic            full
);

    logic [ID_W-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign valid   = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign dout    = valid ? mem[rd_ptr] : ID_W'(ID_NONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // NOTE: storage is not reset; count gates every read so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/irq_queue_ctrl.sv
// Interrupt front-end: edge detect, pending bits, one-grant-per-cycle arbiter, ID FIFO.
// Define IRQ_FIXED_PRIO_EN for fixed priority (largest ID wins); otherwise round-robin.
module irq_queue_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 7,
    parameter int DEPTH = 16,
    localparam int ID_W = id_width(N_SRC),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [N_SRC-1:0] mask,
    input  logic             ack,
    input  logic             clr_drop,
    output logic             irq_valid,
    output logic [ID_W-1:0]  irq_id,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             drop
);

    logic [N_SRC-1:0] prev;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] edges;
    logic [N_SRC-1:0] latch;
    logic [N_SRC-1:0] gnt_vec;
    logic [ID_W-1:0]  push_id;
    grant_t           grant;
    logic             pop;
    logic             grant_en;
    logic             lost;
    int               rr_start;
    logic             high_first;

`ifdef IRQ_FIXED_PRIO_EN
    assign rr_start   = 0;
    assign high_first = 1'b1;
`else
    logic [4:0] rr_ptr;

    assign rr_start   = int'(rr_ptr);
    assign high_first = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_en) begin
            rr_ptr <= (grant.idx == 5'(N_SRC - 1)) ? 5'd0 : grant.idx + 5'd1;
        end
    end
`endif

    assign edges = irq_in & ~prev;
    assign latch = edges & mask;
    assign pop   = ack & irq_valid;

    always_comb begin
        grant = grant_select(MAX_SRC'(pend), N_SRC, rr_start, high_first);
    end

    // A full queue still takes a grant when the head leaves in the same cycle.
    assign grant_en = grant.found & (~full | pop);
    assign gnt_vec  = grant_en ? N_SRC'(MAX_SRC'(1) << grant.idx) : '0;
    assign push_id  = ID_W'(grant.idx) + ID_W'(1);
    assign lost     = |(latch & pend & ~gnt_vec);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= '0;
            pend <= '0;
            drop <= 1'b0;
        end else begin
            prev <= irq_in;
            pend <= (pend & ~gnt_vec) | latch;
            if (lost)          drop <= 1'b1;
            else if (clr_drop) drop <= 1'b0;
        end
    end

    irq_fifo #(
        .DEPTH (DEPTH),
        .ID_W  (ID_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant_en),
        .pop   (pop),
        .din   (push_id),
        .dout  (irq_id),
        .valid (irq_valid),
        .count (count),
        .full  (full)
    );

endmodule

// File: tb/tb_irq_queue_ctrl.sv
// Directed bench for irq_queue_ctrl (N_SRC=7, DEPTH=4); expected IDs come from a scoreboard queue.
// Expected arbitration order follows IRQ_FIXED_PRIO_EN when that macro is defined.
module tb_irq_queue_ctrl;

    localparam int N_SRC = 7;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N_SRC-1:0] irq_in = '0;
    logic [N_SRC-1:0] mask = '1;
    logic             ack = 1'b0;
    logic             clr_drop = 1'b0;
    logic             irq_valid;
    logic [2:0]       irq_id;
    logic [2:0]       count;
    logic             full;
    logic             drop;

    int errors = 0;
    int checks = 0;
    int sb[$];

    always #5 clk = ~clk;

    irq_queue_ctrl #(
        .N_SRC (N_SRC),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .mask      (mask),
        .ack       (ack),
        .clr_drop  (clr_drop),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .count     (count),
        .full      (full),
        .drop      (drop)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        irq_in = '0;
        ack    = 1'b0;
        step(1);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic pulse(input logic [N_SRC-1:0] bits);
        irq_in = bits;
        step(1);
        irq_in = '0;
    endtask

    // Pop the head on every valid cycle, comparing it to the scoreboard, until it is empty.
    task automatic drain(input string tag, input int budget);
        int cyc;
        int exp_id;
        cyc = 0;
        while (sb.size() > 0 && cyc < budget) begin
            if (irq_valid) begin
                exp_id = sb.pop_front();
                check(tag, 32'(irq_id), 32'(exp_id));
                ack = 1'b1;
            end else begin
                ack = 1'b0;
            end
            step(1);
            cyc++;
        end
        ack = 1'b0;
        check({tag, "_left"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int exp_id;

        // Line already high through reset counts as an edge on release.
        rst    = 1'b1;
        irq_in = 7'b0000100;
        step(2);
        check("rst_valid", 32'(irq_valid), 32'd0);
        check("rst_id",    32'(irq_id),    32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_full",  32'(full),      32'd0);
        check("rst_drop",  32'(drop),      32'd0);
        rst = 1'b0;
        sb.push_back(3);
        step(2);
        check("t1_valid", 32'(irq_valid), 32'd1);
        exp_id = sb.pop_front();
        check("t1_id", 32'(irq_id), 32'(exp_id));
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("t1_valid_after_ack", 32'(irq_valid), 32'd0);
        check("t1_id_after_ack",    32'(irq_id),    32'd0);
        irq_in = '0;

        // Simultaneous edges on sources 2, 5 and 7.
        do_reset();
        pulse(7'b1010010);
`ifdef IRQ_FIXED_PRIO_EN
        sb.push_back(7); sb.push_back(5); sb.push_back(2);
`else
        sb.push_back(2); sb.push_back(5); sb.push_back(7);
`endif
        drain("t2_id", 20);
        check("t2_count", 32'(count), 32'd0);

        // Six single-source edges fill the queue and leave two sources pending.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            irq_in = 7'(1 << k);
            step(1);
        end
        irq_in = '0;
        step(2);
        check("t3_count", 32'(count), 32'd4);
        check("t3_full",  32'(full),  32'd1);
        check("t3_drop",  32'(drop),  32'd0);
        sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4);
        exp_id = sb.pop_front();
        check("t3_head", 32'(irq_id), 32'(exp_id));
        ack = 1'b1;
        step(1);
        ack = 1'b0;
`ifdef IRQ_FIXED_PRIO_EN
        sb.push_back(6);
`else
        sb.push_back(5);
`endif
        check("t3_count_after_ack", 32'(count), 32'd4);
        check("t3_full_after_ack",  32'(full),  32'd1);
        check("t3_drop_after_ack",  32'(drop),  32'd0);

        // Second edge on source 4 while it is still pending and the queue is full.
        pulse(7'b0001000);
        step(1);
        check("t4_drop_first", 32'(drop), 32'd0);
        pulse(7'b0001000);
        step(1);
        check("t4_drop_set", 32'(drop),  32'd1);
        check("t4_count",    32'(count), 32'd4);
        clr_drop = 1'b1;
        step(1);
        clr_drop = 1'b0;
        check("t4_drop_clr", 32'(drop), 32'd0);
`ifdef IRQ_FIXED_PRIO_EN
        sb.push_back(5); sb.push_back(4);
`else
        sb.push_back(6); sb.push_back(4);
`endif
        drain("t4_id", 30);
        check("t4_count_end", 32'(count), 32'd0);
        check("t4_valid_end", 32'(irq_valid), 32'd0);
        check("t4_drop_end",  32'(drop), 32'd0);

        // Masked source is ignored, and ack on an empty queue changes nothing.
        do_reset();
        mask = 7'b1111110;
        pulse(7'b0000001);
        step(3);
        check("t5_valid", 32'(irq_valid), 32'd0);
        check("t5_drop",  32'(drop),      32'd0);
        check("t5_count", 32'(count),     32'd0);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("t5_count_empty_ack", 32'(count),     32'd0);
        check("t5_valid_empty_ack", 32'(irq_valid), 32'd0);
        mask = '1;

        // Reset mid-operation discards queued entries in one cycle.
        do_reset();
        pulse(7'b0000111);
        step(5);
        check("t6_count_before", 32'(count), 32'd3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("t6_count", 32'(count),     32'd0);
        check("t6_valid", 32'(irq_valid), 32'd0);
        check("t6_id",    32'(irq_id),    32'd0);
        check("t6_full",  32'(full),      32'd0);
        step(3);
        check("t6_valid_later", 32'(irq_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
